dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) data-memory arbiter with round-robin tie breaking.
// Each transaction: one grant cycle, MEM_LATENCY access cycles, one ack cycle.
module dmem_arbiter #(
   parameter int unsigned WORD_LEN    = 32,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [WORD_LEN-1:0] cpu_addr,
   input  logic [WORD_LEN-1:0] cpu_wdata,
   output logic                cpu_ack,
   output logic [WORD_LEN-1:0] cpu_rdata,
   output logic                cpu_stall,
   input  logic                dbg_req,
   input  logic                dbg_we,
   input  logic [WORD_LEN-1:0] dbg_addr,
   input  logic [WORD_LEN-1:0] dbg_wdata,
   output logic                dbg_ack,
   output logic [WORD_LEN-1:0] dbg_rdata,
   output logic                mem_readEN,
   output logic                mem_writeEN,
   output logic [WORD_LEN-1:0] mem_address,
   output logic [WORD_LEN-1:0] mem_dataIn,
   input  logic [WORD_LEN-1:0] mem_dataOut,
   output logic                busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic PortCpu = 1'b0;
   localparam logic PortDbg = 1'b1;

   state_e              r_state;
   state_e              w_state_d;
   logic [CntW-1:0]     r_cnt;
   logic                r_last_gnt;
   logic                r_owner;
   logic                r_we;
   logic [WORD_LEN-1:0] r_addr;
   logic [WORD_LEN-1:0] r_wdata;
   logic [WORD_LEN-1:0] r_cpu_rdata;
   logic [WORD_LEN-1:0] r_dbg_rdata;

   logic w_any_req;
   logic w_gnt_dbg;
   logic w_grant;
   logic w_cnt_zero;
   logic w_capture;
   logic w_access;
   logic w_done;

   always_comb begin
      w_any_req  = cpu_req | dbg_req;
      // On a tie the port that did not win last time gets the grant.
      w_gnt_dbg  = dbg_req & (~cpu_req | (r_last_gnt == PortCpu));
      w_cnt_zero = (r_cnt == '0);
      w_grant    = 1'b0;
      w_capture  = 1'b0;
      w_state_d  = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_any_req) begin
               w_grant   = 1'b1;
               w_state_d = StAccess;
            end
         end
         StAccess: begin
            if (w_cnt_zero) begin
               w_capture = ~r_we;
               w_state_d = StDone;
            end
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_last_gnt  <= PortDbg;
         r_owner     <= PortCpu;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_gnt_dbg;
            r_we    <= w_gnt_dbg ? dbg_we    : cpu_we;
            r_addr  <= w_gnt_dbg ? dbg_addr  : cpu_addr;
            r_wdata <= w_gnt_dbg ? dbg_wdata : cpu_wdata;
            r_cnt   <= CntLoad;
         end else if ((r_state == StAccess) && !w_cnt_zero) begin
            r_cnt <= r_cnt - CntOne;
         end
         if (w_capture) begin
            if (r_owner == PortDbg) begin
               r_dbg_rdata <= mem_dataOut;
            end else begin
               r_cpu_rdata <= mem_dataOut;
            end
         end
         if (r_state == StDone) begin
            r_last_gnt <= r_owner;
         end
      end
   end

   always_comb begin
      w_access    = (r_state == StAccess);
      w_done      = (r_state == StDone);
      mem_readEN  = w_access & ~r_we;
      // A single write strobe on the final access cycle.
      mem_writeEN = w_access & r_we & w_cnt_zero;
      mem_address = w_access ? r_addr  : '0;
      mem_dataIn  = w_access ? r_wdata : '0;
      cpu_ack     = w_done & (r_owner == PortCpu);
      dbg_ack     = w_done & (r_owner == PortDbg);
      cpu_rdata   = r_cpu_rdata;
      dbg_rdata   = r_dbg_rdata;
      cpu_stall   = cpu_req & ~cpu_ack;
      busy        = (r_state != StIdle);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected acks/writes into queues,
// independent monitors pop and compare whenever the DUT acks or strobes a write.
module tb_dmem_arbiter;

   localparam int unsigned WL  = 32;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [WL-1:0] cpu_addr = '0, cpu_wdata = '0;
   logic          dbg_req = 1'b0, dbg_we = 1'b0;
   logic [WL-1:0] dbg_addr = '0, dbg_wdata = '0;
   logic          cpu_ack, dbg_ack, cpu_stall, busy;
   logic [WL-1:0] cpu_rdata, dbg_rdata;
   logic          mem_readEN, mem_writeEN;
   logic [WL-1:0] mem_address, mem_dataIn, mem_dataOut;

   dmem_arbiter #(.WORD_LEN(WL), .MEM_LATENCY(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .dbg_req     (dbg_req),
      .dbg_we      (dbg_we),
      .dbg_addr    (dbg_addr),
      .dbg_wdata   (dbg_wdata),
      .dbg_ack     (dbg_ack),
      .dbg_rdata   (dbg_rdata),
      .mem_readEN  (mem_readEN),
      .mem_writeEN (mem_writeEN),
      .mem_address (mem_address),
      .mem_dataIn  (mem_dataIn),
      .mem_dataOut (mem_dataOut),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: unwritten word i reads as 0xA50000ii.
   logic [WL-1:0] mem     [0:63];
   bit            written [0:63];
   logic [5:0]    w_idx;
   assign w_idx = mem_address[7:2];
   always @(posedge clk) begin
      if (mem_writeEN) begin
         mem[w_idx]     <= mem_dataIn;
         written[w_idx] <= 1'b1;
      end
   end
   assign mem_dataOut = !mem_readEN ? '0 :
                        written[w_idx] ? mem[w_idx] : (32'hA500_0000 | {26'd0, w_idx});

   typedef struct {
      bit            port;
      bit            rd;
      logic [WL-1:0] data;
      int            c;
   } ack_t;
   typedef struct {
      logic [WL-1:0] addr;
      logic [WL-1:0] data;
      int            c;
   } wr_t;

   ack_t          aq[$];
   wr_t           wq[$];
   logic [WL-1:0] m_cpu_rd = '0;
   logic [WL-1:0] m_dbg_rd = '0;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit port, input bit req, input bit we,
                        input logic [WL-1:0] a, input logic [WL-1:0] d);
      if (port == 1'b0) begin
         cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end else begin
         dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
      end
   endtask

   task automatic push_ack(input bit port, input bit rd, input logic [WL-1:0] data, input int c);
      ack_t e;
      e.port = port; e.rd = rd; e.data = data; e.c = c;
      aq.push_back(e);
   endtask

   task automatic push_wr(input logic [WL-1:0] a, input logic [WL-1:0] d, input int c);
      wr_t e;
      e.addr = a; e.data = d; e.c = c;
      wq.push_back(e);
   endtask

   // One isolated transaction; inputs are scrambled (or req dropped) after grant.
   task automatic single(input bit port, input bit we, input logic [WL-1:0] a,
                         input logic [WL-1:0] d, input logic [WL-1:0] exp_rd, input bit drop);
      int c;
      @(negedge clk);
      c = cyc;
      drive(port, 1'b1, we, a, d);
      push_ack(port, !we, exp_rd, c + 3);
      if (we) push_wr(a, d, c + 2);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (drop) drive(port, 1'b0, 1'b0, '0, '0);
            else      drive(port, 1'b1, !we, ~a, ~d);
         end
         if (k <= 2) begin
            check("busy in access", busy, 1'b1);
            check("access address", mem_address, a);
            check("access dataIn", mem_dataIn, d);
            check("access readEN", mem_readEN, !we);
         end else if (k == 3) begin
            check("done address", mem_address, '0);
            check("done readEN", mem_readEN, 1'b0);
            drive(port, 1'b0, 1'b0, '0, '0);
         end else begin
            check("idle after done", busy, 1'b0);
         end
      end
   endtask

   // Ack scoreboard monitor.
   initial begin
      ack_t e;
      forever begin
         @(negedge clk);
         if (cpu_ack || dbg_ack) begin
            check("acks exclusive", cpu_ack & dbg_ack, 1'b0);
            if (aq.size() == 0) begin
               check("unexpected ack", {cpu_ack, dbg_ack}, 2'b00);
            end else begin
               e = aq.pop_front();
               check("ack port", {cpu_ack, dbg_ack}, e.port ? 2'b01 : 2'b10);
               check("ack cycle", cyc, e.c);
               if (e.rd) begin
                  if (e.port) m_dbg_rd = e.data;
                  else        m_cpu_rd = e.data;
               end
               check("cpu_rdata at ack", cpu_rdata, m_cpu_rd);
               check("dbg_rdata at ack", dbg_rdata, m_dbg_rd);
            end
         end
      end
   end

   // Memory-write scoreboard monitor.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (mem_writeEN) begin
            if (wq.size() == 0) begin
               check("unexpected write", mem_writeEN, 1'b0);
            end else begin
               e = wq.pop_front();
               check("write address", mem_address, e.addr);
               check("write data", mem_dataIn, e.data);
               check("write cycle", cyc, e.c);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset cpu_ack", cpu_ack, 1'b0);
      check("reset dbg_ack", dbg_ack, 1'b0);
      check("reset readEN", mem_readEN, 1'b0);
      check("reset writeEN", mem_writeEN, 1'b0);
      check("reset address", mem_address, '0);
      check("reset dataIn", mem_dataIn, '0);
      check("reset cpu_rdata", cpu_rdata, '0);
      check("reset dbg_rdata", dbg_rdata, '0);
      rst = 1'b1;

      single(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, '0, 1'b0);
      single(1'b0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0);
      single(1'b1, 1'b0, 32'h20, '0, 32'hA500_0008, 1'b0);
      single(1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, '0, 1'b0);
      single(1'b0, 1'b0, 32'h24, '0, 32'h0BAD_F00D, 1'b0);

      // CPU request raised while DBG is mid-access: stall until its own ack.
      @(negedge clk);
      c = cyc;
      drive(1'b1, 1'b1, 1'b0, 32'h10, '0);
      push_ack(1'b1, 1'b1, 32'hDEAD_BEEF, c + 3);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
      push_ack(1'b0, 1'b1, 32'hA500_0008, c + 7);
      #1;
      check("stall on req", cpu_stall, 1'b1);
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         if (k == 3) drive(1'b1, 1'b0, 1'b0, '0, '0);
         check("stall window", cpu_stall, (k < 7));
         if (k == 7) drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      check("idle after stall test", busy, 1'b0);

      // DBG drops req in the first access cycle; ack must still pulse.
      single(1'b1, 1'b0, 32'h28, '0, 32'hA500_000A, 1'b1);

      // Reset during the first access cycle of a write aborts it.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
      @(negedge clk);
      rst = 1'b0;
      m_cpu_rd = '0;
      m_dbg_rd = '0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort writeEN", mem_writeEN, 1'b0);
      check("abort cpu_ack", cpu_ack, 1'b0);
      check("abort address", mem_address, '0);
      check("abort cpu_rdata", cpu_rdata, '0);
      check("abort dbg_rdata", dbg_rdata, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (2) begin
         @(negedge clk);
         check("held reset writeEN", mem_writeEN, 1'b0);
      end

      // Release reset with both ports requesting: CPU, DBG, CPU, DBG.
      @(negedge clk);
      rst = 1'b1;
      c = cyc;
      drive(1'b0, 1'b1, 1'b0, 32'h30, '0);
      drive(1'b1, 1'b1, 1'b0, 32'h10, '0);
      push_ack(1'b0, 1'b1, 32'hA500_000C, c + 3);
      push_ack(1'b1, 1'b1, 32'hDEAD_BEEF, c + 7);
      push_ack(1'b0, 1'b1, 32'hA500_000C, c + 11);
      push_ack(1'b1, 1'b1, 32'hDEAD_BEEF, c + 15);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 15) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            drive(1'b1, 1'b0, 1'b0, '0, '0);
         end
      end
      @(negedge clk);
      check("idle after round robin", busy, 1'b0);

      repeat (4) @(negedge clk);
      check("pending acks", aq.size(), 0);
      check("pending writes", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
